pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Data-hazard control for an in-order pipeline: tracks in-flight destinations
// behind ID and produces stall/flush/forward-select decisions plus a stall counter.
module pipe_hazard_ctrl #(
   parameter int  RBITS      = 5,
   parameter int  DEPTH      = 3,
   parameter int  LOAD_STAGE = 1,
   parameter int  FWD_EN     = 1,
   localparam int FW         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [RBITS-1:0] id_rs,
   input  logic [RBITS-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [RBITS-1:0] id_rd,
   input  logic             id_regwr,
   input  logic             id_is_load,
   input  logic             branch_taken,
   output logic             stall,
   output logic             flush,
   output logic [FW-1:0]    fwd_a,
   output logic [FW-1:0]    fwd_b,
   output logic [15:0]      stall_cnt
);

   // Scoreboard: index 0 is EX, higher index is older.
   logic [DEPTH-1:0]            ent_v_q;
   logic [DEPTH-1:0]            ent_ld_q;
   logic [DEPTH-1:0][RBITS-1:0] ent_rd_q;
   logic                        ent0_v_d;
   logic [15:0]                 stall_cnt_q;
   logic [15:0]                 stall_cnt_d;

   logic          hit_a_s, early_a_s, haz_a_s;
   logic          hit_b_s, early_b_s, haz_b_s;
   logic [FW-1:0] code_a_s, code_b_s;

   // Returns {hit, load-not-yet-forwardable, forward code} for the youngest matching entry.
   function automatic logic [FW+1:0] lookup(
      input logic                        use_src,
      input logic [RBITS-1:0]            src,
      input logic [DEPTH-1:0]            v,
      input logic [DEPTH-1:0]            ld,
      input logic [DEPTH-1:0][RBITS-1:0] rd
   );
      logic          hit;
      logic          early;
      logic [FW-1:0] code;
      hit   = 1'b0;
      early = 1'b0;
      code  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (use_src && (src != '0) && v[i] && (rd[i] == src)) begin
            hit   = 1'b1;
            early = ld[i] && (i < LOAD_STAGE);
            code  = FW'(i + 1);
         end else begin
            hit   = hit;
         end
      end
      return {hit, early, code};
   endfunction

   // Hazard detection, forward selection and next-state for the scoreboard head and counter.
   always_comb begin
      {hit_a_s, early_a_s, code_a_s} = lookup(id_use_rs, id_rs, ent_v_q, ent_ld_q, ent_rd_q);
      {hit_b_s, early_b_s, code_b_s} = lookup(id_use_rt, id_rt, ent_v_q, ent_ld_q, ent_rd_q);
      haz_a_s = 1'b0;
      haz_b_s = 1'b0;
      fwd_a   = '0;
      fwd_b   = '0;
      if (FWD_EN != 0) begin
         haz_a_s = early_a_s;
         haz_b_s = early_b_s;
         fwd_a   = (rst_n && !haz_a_s) ? code_a_s : '0;
         fwd_b   = (rst_n && !haz_b_s) ? code_b_s : '0;
      end else begin
         haz_a_s = hit_a_s;
         haz_b_s = hit_b_s;
      end
      flush    = branch_taken;
      stall    = rst_n & id_valid & ~branch_taken & (haz_a_s | haz_b_s);
      ent0_v_d = id_valid & id_regwr & (id_rd != '0) & ~stall & ~branch_taken;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Scoreboard shift and stall counter, on the pipeline's falling edge.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_v_q     <= '0;
         ent_ld_q    <= '0;
         ent_rd_q    <= '0;
         stall_cnt_q <= 16'd0;
      end else begin
         ent_v_q     <= {ent_v_q[DEPTH-2:0], ent0_v_d};
         ent_ld_q    <= {ent_ld_q[DEPTH-2:0], id_is_load};
         ent_rd_q    <= {ent_rd_q[DEPTH-2:0], id_rd};
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance, a stall-only
// instance (DEPTH=3) and a stall-only DEPTH=8 instance for counter saturation.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_use_rs, id_use_rt, id_regwr, id_is_load, branch_taken;

   logic        stall_def, flush_def, stall_nf, flush_nf, stall_sat, flush_sat;
   logic [1:0]  fwd_a_def, fwd_b_def, fwd_a_nf, fwd_b_nf;
   logic [3:0]  fwd_a_sat, fwd_b_sat;
   logic [15:0] cnt_def, cnt_nf, cnt_sat;

   int total;
   int fails;

   pipe_hazard_ctrl #(.RBITS(5), .DEPTH(3), .LOAD_STAGE(1), .FWD_EN(1)) u_def (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .branch_taken(branch_taken), .stall(stall_def),
      .flush(flush_def), .fwd_a(fwd_a_def), .fwd_b(fwd_b_def), .stall_cnt(cnt_def));

   pipe_hazard_ctrl #(.RBITS(5), .DEPTH(3), .LOAD_STAGE(1), .FWD_EN(0)) u_nf (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .branch_taken(branch_taken), .stall(stall_nf),
      .flush(flush_nf), .fwd_a(fwd_a_nf), .fwd_b(fwd_b_nf), .stall_cnt(cnt_nf));

   pipe_hazard_ctrl #(.RBITS(5), .DEPTH(8), .LOAD_STAGE(1), .FWD_EN(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
      .id_is_load(id_is_load), .branch_taken(branch_taken), .stall(stall_sat),
      .flush(flush_sat), .fwd_a(fwd_a_sat), .fwd_b(fwd_b_sat), .stall_cnt(cnt_sat));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwr = 1'b0; id_is_load = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int k = 0; k < 10; k++) tick();
   endtask

   // ID instruction that writes rd (optionally a load) and reads nothing.
   task automatic producer(input logic [4:0] rd, input logic ld);
      idle();
      id_valid = 1'b1; id_regwr = 1'b1; id_rd = rd; id_is_load = ld;
   endtask

   // ID instruction that reads rs/rt and writes nothing.
   task automatic consumer(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
      idle();
      id_valid = 1'b1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
   endtask

   initial begin
      total = 0;
      fails = 0;
      rst_n = 1'b0;
      idle();
      branch_taken = 1'b1;
      #3;
      check("rst_stall", 32'(stall_def), 32'd0);
      check("rst_flush", 32'(flush_def), 32'd1);
      check("rst_fwd_a", 32'(fwd_a_def), 32'd0);
      check("rst_cnt", 32'(cnt_def), 32'd0);
      branch_taken = 1'b0;
      #4;
      rst_n = 1'b1;
      tick();

      // add r3, then three consumers of r3: forward from EX, MEM, WR, then none
      producer(5'd3, 1'b0);
      #1 check("add_issue_stall", 32'(stall_def), 32'd0);
      tick();
      consumer(5'd3, 1'b1, 5'd0, 1'b0);
      #1 check("fwd_ex_stall", 32'(stall_def), 32'd0);
      check("fwd_ex", 32'(fwd_a_def), 32'd1);
      check("flush_low", 32'(flush_def), 32'd0);
      tick();
      check("fwd_mem", 32'(fwd_a_def), 32'd2);
      tick();
      check("fwd_wr", 32'(fwd_a_def), 32'd3);
      tick();
      check("fwd_none", 32'(fwd_a_def), 32'd0);
      drain();

      // lw r5, dependent on rt: one stall cycle, then forward from MEM
      producer(5'd5, 1'b1);
      tick();
      consumer(5'd0, 1'b0, 5'd5, 1'b1);
      #1 check("ldu_stall", 32'(stall_def), 32'd1);
      check("ldu_fwd_b0", 32'(fwd_b_def), 32'd0);
      check("ldu_cnt0", 32'(cnt_def), 32'd0);
      tick();
      check("ldu_cnt1", 32'(cnt_def), 32'd1);
      check("ldu_stall_end", 32'(stall_def), 32'd0);
      check("ldu_fwd_b", 32'(fwd_b_def), 32'd2);
      drain();

      // stall-only mode: add r4 then dependent -> 3 stall cycles, then issue
      producer(5'd4, 1'b0);
      tick();
      idle();
      id_valid = 1'b1; id_rs = 5'd4; id_use_rs = 1'b1; id_regwr = 1'b1; id_rd = 5'd6;
      for (int k = 0; k < 3; k++) begin
         #1 check("nf_stall", 32'(stall_nf), 32'd1);
         check("nf_fwd_a", 32'(fwd_a_nf), 32'd0);
         tick();
      end
      check("nf_drained", 32'(stall_nf), 32'd0);
      check("nf_fwd_a_end", 32'(fwd_a_nf), 32'd0);
      tick();
      consumer(5'd6, 1'b1, 5'd0, 1'b0);
      #1 check("nf_issued", 32'(stall_nf), 32'd1);
      drain();

      // lw r5 then dependent load with a taken branch: flush wins, head is a bubble
      producer(5'd5, 1'b1);
      tick();
      idle();
      id_valid = 1'b1; id_rt = 5'd5; id_use_rt = 1'b1; id_regwr = 1'b1;
      id_rd = 5'd5; id_is_load = 1'b1; branch_taken = 1'b1;
      #1 check("br_flush", 32'(flush_def), 32'd1);
      check("br_stall", 32'(stall_def), 32'd0);
      tick();
      consumer(5'd5, 1'b1, 5'd0, 1'b0);
      #1 check("br_bubble_stall", 32'(stall_def), 32'd0);
      check("br_bubble_fwd", 32'(fwd_a_def), 32'd2);
      drain();

      // writes to r0 never match
      producer(5'd0, 1'b0);
      tick();
      consumer(5'd0, 1'b1, 5'd0, 1'b1);
      #1 check("r0_stall", 32'(stall_def), 32'd0);
      check("r0_stall_nf", 32'(stall_nf), 32'd0);
      check("r0_fwd_a", 32'(fwd_a_def), 32'd0);
      check("r0_fwd_b", 32'(fwd_b_def), 32'd0);
      tick();
      // unused source does not match a pending r7
      producer(5'd7, 1'b1);
      tick();
      consumer(5'd7, 1'b0, 5'd2, 1'b1);
      #1 check("unused_stall", 32'(stall_def), 32'd0);
      check("unused_stall_nf", 32'(stall_nf), 32'd0);
      check("unused_fwd_a", 32'(fwd_a_def), 32'd0);
      drain();

      // self-dependent writer of r1 in stall-only DEPTH=8: stalls 8 of every 9 edges
      idle();
      id_valid = 1'b1; id_rs = 5'd1; id_use_rs = 1'b1; id_regwr = 1'b1; id_rd = 5'd1;
      for (int k = 0; k < 74000; k++) tick();
      check("sat_cnt", 32'(cnt_sat), 32'h0000FFFF);
      check("sat_stall", 32'(stall_sat), 32'd1);
      #1 rst_n = 1'b0;
      #1 check("rst_mid_stall", 32'(stall_sat), 32'd0);
      check("rst_mid_cnt", 32'(cnt_sat), 32'd0);
      check("rst_mid_cnt_def", 32'(cnt_def), 32'd0);
      #1 rst_n = 1'b1;
      tick();

      // first edge after reset behaves normally
      producer(5'd3, 1'b0);
      tick();
      consumer(5'd3, 1'b1, 5'd0, 1'b0);
      #1 check("post_rst_fwd", 32'(fwd_a_def), 32'd1);
      check("post_rst_stall", 32'(stall_def), 32'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
